// File: rtl/sb_pkg.sv
// Shared types and constants for the issue-stage scoreboard.
package sb_pkg;

   // Execute-unit writeback latencies (issue edge to retire edge)
   localparam int LAT_ALU   = 1;
   localparam int LAT_LOAD  = 2;
   localparam int LAT_FPADD = 3;
   localparam int LAT_FPMUL = 4;

   // Default geometry; the slot rd field is sized for SB_NREGS registers
   localparam int SB_NREGS   = 32;
   localparam int SB_RW      = $clog2(SB_NREGS);
   localparam int SB_MAX_LAT = 8;
   localparam int SB_LW      = $clog2(SB_MAX_LAT + 1);

   // One writeback-port reservation: slot k retires k edges from now
   typedef struct packed {
      logic             v;
      logic [SB_RW-1:0] rd;
   } slot_t;

endpackage

// File: rtl/wb_reservation_shift.sv
// Writeback-port reservation shift register: one slot per future cycle,
// shifts toward slot 0 every edge, with an indexed insert for new issues.
module wb_reservation_shift
   import sb_pkg::*;
#(
   parameter int MAX_LAT = SB_MAX_LAT,
   parameter int LW      = $clog2(MAX_LAT + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ins_en,
   input  logic [LW-1:0]      ins_idx,
   input  logic [SB_RW-1:0]   ins_rd,
   output logic [MAX_LAT-1:0] slot_v,
   output slot_t              head
);

   slot_t slot_q [MAX_LAT];
   slot_t slot_d [MAX_LAT];

   // Shift toward the port; the insert overrides whatever shifted in
   always_comb begin
      for (int k = 0; k < MAX_LAT; k++) slot_d[k] = '0;
      for (int k = 0; k < MAX_LAT - 1; k++) slot_d[k] = slot_q[k+1];
      for (int k = 0; k < MAX_LAT; k++) begin
         if (ins_en && ins_idx == LW'(k)) slot_d[k] = '{v: 1'b1, rd: ins_rd};
      end
   end

   // Slot registers; reset drops every reservation
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < MAX_LAT; k++) slot_q[k] <= '0;
      end else begin
         for (int k = 0; k < MAX_LAT; k++) slot_q[k] <= slot_d[k];
      end
   end

   // Expose occupancy for port-conflict checks
   always_comb begin
      for (int k = 0; k < MAX_LAT; k++) slot_v[k] = slot_q[k].v;
   end

   assign head = slot_q[0];

endmodule

// File: rtl/pipe_scoreboard.sv
// Issue-stage scoreboard: per-register pending counters plus a writeback
// reservation shift register; stalls decode on RAW, WAW, port conflicts
// and illegal latencies.
module pipe_scoreboard
   import sb_pkg::*;
#(
   parameter  int NREGS   = SB_NREGS,
   parameter  int MAX_LAT = SB_MAX_LAT,
   parameter  int FWD_WIN = 1,
   localparam int RW      = $clog2(NREGS),
   localparam int LW      = $clog2(MAX_LAT + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [RW-1:0]    issue_rs1,
   input  logic [RW-1:0]    issue_rs2,
   input  logic             issue_use1,
   input  logic             issue_use2,
   input  logic [RW-1:0]    issue_rd,
   input  logic             issue_we,
   input  logic [LW-1:0]    issue_lat,
   output logic             wb_valid,
   output logic [RW-1:0]    wb_rd,
   output logic [NREGS-1:0] busy_mask,
   output logic             lat_err
);

   logic [LW-1:0]      cnt_q [NREGS];
   logic [LW-1:0]      cnt_d [NREGS];
   logic               lat_err_q, lat_err_d;
   logic [MAX_LAT-1:0] slot_v;
   slot_t              head;
   logic               raw, waw, port, bad, accept, reserve;

   // Stall terms, all from current state; ready does not look at valid
   always_comb begin
      raw = (issue_use1 && issue_rs1 != '0 && cnt_q[issue_rs1] > LW'(FWD_WIN)) ||
            (issue_use2 && issue_rs2 != '0 && cnt_q[issue_rs2] > LW'(FWD_WIN));
      // A new write must retire strictly after any pending one to the same rd
      waw = issue_we && issue_rd != '0 && cnt_q[issue_rd] >= issue_lat;
      // slot[lat] shifts into slot[lat-1] this edge, exactly where we would insert
      port = 1'b0;
      for (int k = 0; k < MAX_LAT; k++) begin
         if (issue_lat == LW'(k)) port = issue_we && issue_rd != '0 && slot_v[k];
      end
      bad         = issue_lat == '0 || issue_lat > LW'(MAX_LAT);
      issue_ready = !(raw || waw || port || bad);
      accept      = issue_valid && issue_ready;
      reserve     = accept && issue_we && issue_rd != '0;
   end

   // Counters count down to retire; an accepted issue reloads its rd
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LW'(1) : cnt_q[r];
      end
      if (reserve) cnt_d[issue_rd] = issue_lat;
      lat_err_d = lat_err_q || (bad && issue_valid);
   end

   // Counter and sticky-error registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
         lat_err_q <= 1'b0;
      end else begin
         for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
         lat_err_q <= lat_err_d;
      end
   end

   // Busy view of the pending counters
   always_comb begin
      for (int r = 0; r < NREGS; r++) busy_mask[r] = cnt_q[r] != '0;
   end

   wb_reservation_shift #(.MAX_LAT(MAX_LAT), .LW(LW)) u_wb_res (
      .clk     (clk),
      .reset   (reset),
      .ins_en  (reserve),
      .ins_idx (issue_lat - LW'(1)),
      .ins_rd  (SB_RW'(issue_rd)),
      .slot_v  (slot_v),
      .head    (head)
   );

   assign wb_valid = head.v;
   assign wb_rd    = RW'(head.rd);
   assign lat_err  = lat_err_q;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: stimulus pushes expected writebacks
// (rd, cycle) into a queue; a negedge monitor pops and compares.
module tb_pipe_scoreboard;

   localparam int NREGS   = 32;
   localparam int MAX_LAT = 8;
   localparam int RW      = $clog2(NREGS);
   localparam int LW      = $clog2(MAX_LAT + 1);

   logic             clk = 1'b0;
   logic             reset;
   logic             issue_valid, issue_ready;
   logic [RW-1:0]    issue_rs1, issue_rs2, issue_rd, wb_rd;
   logic             issue_use1, issue_use2, issue_we, wb_valid, lat_err;
   logic [LW-1:0]    issue_lat;
   logic [NREGS-1:0] busy_mask;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int rd;
      int at;
   } exp_t;
   exp_t exp_q[$];

   pipe_scoreboard #(.NREGS(NREGS), .MAX_LAT(MAX_LAT), .FWD_WIN(1)) dut (
      .clk         (clk),
      .reset       (reset),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_rs1   (issue_rs1),
      .issue_rs2   (issue_rs2),
      .issue_use1  (issue_use1),
      .issue_use2  (issue_use2),
      .issue_rd    (issue_rd),
      .issue_we    (issue_we),
      .issue_lat   (issue_lat),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .busy_mask   (busy_mask),
      .lat_err     (lat_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present one instruction for a cycle, check ready, and on an expected
   // accept of a real write record when its writeback must appear.
   task automatic step(input logic v, input int rs1, input int u1, input int rs2,
                       input int u2, input int rd, input int we, input int lat,
                       input logic exp_rdy, input string name);
      @(negedge clk);
      issue_valid = v;
      issue_rs1   = RW'(rs1);
      issue_use1  = (u1 != 0);
      issue_rs2   = RW'(rs2);
      issue_use2  = (u2 != 0);
      issue_rd    = RW'(rd);
      issue_we    = (we != 0);
      issue_lat   = LW'(lat);
      #1 chk(name, {31'd0, issue_ready}, {31'd0, exp_rdy});
      @(posedge clk);
      #1;
      if (v && exp_rdy && we != 0 && rd != 0) exp_q.push_back('{rd: rd, at: cyc + lat - 1});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 0, 0, 1, 1'b1, "idle_ready");
   endtask

   // Writeback monitor
   always @(negedge clk) begin
      if (!reset && wb_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL wb_unexpected: got rd=%0d at cycle %0d, expected no writeback", wb_rd, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (wb_rd !== RW'(e.rd) || cyc != e.at) begin
               bad++;
               $display("FAIL wb_order: got rd=%0d cycle=%0d expected rd=%0d cycle=%0d",
                        wb_rd, cyc, e.rd, e.at);
            end
         end
      end
   end

   initial begin
      reset = 1'b0;
      issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_use1 = 1'b0;
      issue_use2 = 1'b0; issue_rd = '0; issue_we = 1'b0; issue_lat = '0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_busy", busy_mask, 32'h0);
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
      chk("rst_lat_err", {31'd0, lat_err}, 32'd0);
      // lat 0 without valid: not ready, but no error
      step(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, "lat0_novalid_ready");
      chk("lat0_novalid_err", {31'd0, lat_err}, 32'd0);

      // 1: reset mid-flight drops the reservation
      step(1'b1, 0, 0, 0, 0, 5, 1, 4, 1'b1, "t1_issue");
      chk("t1_busy", busy_mask, 32'h20);
      idle(2);
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      #1;
      chk("t1_rst_busy", busy_mask, 32'h0);
      chk("t1_rst_wb", {31'd0, wb_valid}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("t1_after_busy", busy_mask, 32'h0);
      idle(6);

      // 2a: RAW on a lat-4 producer stalls while cnt > 1
      step(1'b1, 0, 0, 0, 0, 7, 1, 4, 1'b1, "t2a_prod");
      chk("t2a_busy", busy_mask, 32'h80);
      step(1'b1, 7, 1, 0, 0, 0, 0, 1, 1'b0, "t2a_stall_cnt4");
      step(1'b1, 7, 1, 0, 0, 0, 0, 1, 1'b0, "t2a_stall_cnt3");
      step(1'b1, 7, 1, 0, 0, 0, 0, 1, 1'b0, "t2a_stall_cnt2");
      step(1'b1, 7, 1, 0, 0, 0, 0, 1, 1'b1, "t2a_fwd_cnt1");
      // 2b: lat-1 producer never stalls its consumer
      step(1'b1, 0, 0, 0, 0, 8, 1, 1, 1'b1, "t2b_prod");
      step(1'b1, 0, 0, 8, 1, 0, 0, 1, 1'b1, "t2b_consumer");
      idle(MAX_LAT + 1);

      // 3: WAW, lat-1 write behind lat-4 write to the same rd
      step(1'b1, 0, 0, 0, 0, 3, 1, 4, 1'b1, "t3_old");
      for (int i = 0; i < 4; i++) step(1'b1, 0, 0, 0, 0, 3, 1, 1, 1'b0, "t3_waw_stall");
      step(1'b1, 0, 0, 0, 0, 3, 1, 1, 1'b1, "t3_new");
      idle(MAX_LAT + 1);

      // 4: writeback-port conflict
      step(1'b1, 0, 0, 0, 0, 1, 1, 3, 1'b1, "t4_first");
      step(1'b1, 0, 0, 0, 0, 2, 1, 2, 1'b0, "t4_port_stall");
      step(1'b1, 0, 0, 0, 0, 2, 1, 2, 1'b1, "t4_second");
      idle(MAX_LAT + 1);

      // 5: x0 destination and we=0 reserve nothing
      step(1'b1, 0, 0, 0, 0, 0, 1, 4, 1'b1, "t5_x0");
      step(1'b1, 0, 0, 0, 0, 6, 0, 4, 1'b1, "t5_nowe");
      chk("t5_busy", busy_mask, 32'h0);
      idle(MAX_LAT + 1);

      // 6: illegal latency is held and sets a sticky error
      step(1'b1, 0, 0, 0, 0, 4, 1, 0, 1'b0, "t6_lat0_ready");
      chk("t6_lat0_err", {31'd0, lat_err}, 32'd1);
      step(1'b1, 0, 0, 0, 0, 4, 1, 9, 1'b0, "t6_lat9_ready");
      chk("t6_lat9_err", {31'd0, lat_err}, 32'd1);
      idle(2);
      chk("t6_sticky", {31'd0, lat_err}, 32'd1);
      chk("t6_busy", busy_mask, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1 chk("t6_err_cleared", {31'd0, lat_err}, 32'd0);

      idle(MAX_LAT + 1);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
